mmm_input_streamer: RTL and testbench

//  AXI-Stream master that feeds the MMM block's input port. Host software fills

---
 rtl/mmm_input_streamer.sv | 204 ++++++++++++++++++++
 tb/tb_mmm_input_streamer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mmm_input_streamer.sv
// rtl/mmm_input_streamer.sv - streams host-loaded A then B buffers into the MMM input port
// Sync-read buffers feed a 2-entry output queue so the stream runs at one beat per clock.
module mmm_input_streamer #(
  parameter int INW    = 12,
  parameter int M      = 7,
  parameter int N      = 9,
  parameter int MAXK   = 8,
  parameter int K_BITS = $clog2(MAXK + 1),
  parameter int WA_W   = $clog2(MAXK * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [WA_W-1:0]   wr_addr,
  input  logic [INW-1:0]    wr_data,
  input  logic              start,
  input  logic [K_BITS-1:0] start_k,
  input  logic              start_new_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [INW-1:0]    OUT_TDATA,
  output logic              OUT_TVALID,
  output logic [K_BITS:0]   OUT_TUSER,
  input  logic              OUT_TREADY
);

  localparam int A_SZ    = M * MAXK;
  localparam int B_SZ    = MAXK * N;
  localparam int A_AW    = $clog2(A_SZ);
  localparam int B_AW    = $clog2(B_SZ);
  localparam int CNT_MAX = (A_SZ > B_SZ) ? A_SZ : B_SZ;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, FINISH} state_t;

  state_t              state;
  logic [K_BITS-1:0]   k_q;
  logic                new_b_q;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic [CNT_W-1:0]    a_last;
  logic [CNT_W-1:0]    b_last;
  logic                rd_active;
  logic                rd_phase_b;
  logic                rd_valid_q;
  logic                rd_sel_q;
  logic [1:0]          occ;
  logic [2:0]          inflight;
  logic [INW-1:0]      a_q;
  logic [INW-1:0]      b_q;
  logic [INW-1:0]      ram_q;
  logic [INW-1:0]      skid;
  logic                pop;
  logic                push;
  logic                rd_en;
  logic                start_ok;
  logic                host_wr;

  logic [INW-1:0] a_mem [A_SZ];
  logic [INW-1:0] b_mem [B_SZ];

  assign a_last   = CNT_W'(M) * CNT_W'(k_q) - CNT_W'(1);
  assign b_last   = CNT_W'(N) * CNT_W'(k_q) - CNT_W'(1);
  assign start_ok = start && (state == IDLE) && (start_k != '0) && (start_k <= K_BITS'(MAXK));
  assign host_wr  = wr_en && !busy;
  assign pop      = OUT_TVALID && OUT_TREADY;
  assign push     = rd_valid_q;
  assign ram_q    = rd_sel_q ? b_q : a_q;
  // Reads in flight plus queued entries never exceed the two queue slots.
  assign inflight = 3'(occ) + 3'(rd_valid_q);
  assign rd_en    = rd_active && ((inflight < 3'd2) || pop);

  always_ff @(posedge clk) begin
    if (host_wr && !wr_sel && ({1'b0, wr_addr} < (WA_W + 1)'(A_SZ)))
      a_mem[wr_addr[A_AW-1:0]] <= wr_data;
    if (host_wr && wr_sel && ({1'b0, wr_addr} < (WA_W + 1)'(B_SZ)))
      b_mem[wr_addr[B_AW-1:0]] <= wr_data;
    if (rd_en && !rd_phase_b)
      a_q <= a_mem[rd_cnt[A_AW-1:0]];
    if (rd_en && rd_phase_b)
      b_q <= b_mem[rd_cnt[B_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      OUT_TVALID <= 1'b0;
      OUT_TDATA  <= '0;
      OUT_TUSER  <= '0;
      k_q        <= '0;
      new_b_q    <= 1'b0;
      beat_cnt   <= '0;
      rd_cnt     <= '0;
      rd_active  <= 1'b0;
      rd_phase_b <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      occ        <= 2'd0;
      skid       <= '0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      rd_valid_q <= rd_en;
      rd_sel_q   <= rd_phase_b;

      // Read sequencer runs ahead of the handshakes, crossing A->B without a bubble.
      if (rd_en) begin
        if (!rd_phase_b && rd_cnt == a_last) begin
          rd_cnt <= '0;
          if (new_b_q) rd_phase_b <= 1'b1;
          else         rd_active  <= 1'b0;
        end else if (rd_phase_b && rd_cnt == b_last) begin
          rd_cnt    <= '0;
          rd_active <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end

      case (occ)
        2'd0: begin
          if (push) begin
            OUT_TDATA  <= ram_q;
            OUT_TVALID <= 1'b1;
            occ        <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            OUT_TDATA <= ram_q;
          end else if (pop) begin
            OUT_TVALID <= 1'b0;
            occ        <= 2'd0;
          end else if (push) begin
            skid <= ram_q;
            occ  <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            OUT_TDATA <= skid;
            if (push) skid <= ram_q;
            else      occ  <= 2'd1;
          end
        end
      endcase

      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= SEND_A;
            busy       <= 1'b1;
            k_q        <= start_k;
            new_b_q    <= start_new_b;
            OUT_TUSER  <= {start_k, start_new_b};
            beat_cnt   <= '0;
            rd_cnt     <= '0;
            rd_active  <= 1'b1;
            rd_phase_b <= 1'b0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        SEND_A: begin
          if (pop) begin
            if (beat_cnt == a_last) begin
              beat_cnt <= '0;
              if (new_b_q) begin
                state <= SEND_B;
              end else begin
                state <= FINISH;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        SEND_B: begin
          if (pop) begin
            if (beat_cnt == b_last) begin
              beat_cnt <= '0;
              state    <= FINISH;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_input_streamer.sv
// tb/tb_mmm_input_streamer.sv - directed bench for mmm_input_streamer
// Each table row is one transfer set with its own TREADY pattern and expected beat count.
`timescale 1ns/1ps
module tb_mmm_input_streamer;
  localparam int INW  = 12;
  localparam int M    = 7;
  localparam int N    = 9;
  localparam int MAXK = 8;
  localparam int KB   = 4;
  localparam int AW   = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           wr_en = 1'b0;
  logic           wr_sel = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [INW-1:0] wr_data = '0;
  logic           start = 1'b0;
  logic [KB-1:0]  start_k = '0;
  logic           start_new_b = 1'b0;
  logic           busy;
  logic           done;
  logic           err;
  logic [INW-1:0] OUT_TDATA;
  logic           OUT_TVALID;
  logic [KB:0]    OUT_TUSER;
  logic           OUT_TREADY = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic [INW-1:0] a_mdl [56];
  logic [INW-1:0] b_mdl [72];

  typedef struct {
    int k;
    bit nb;
    int mode;
    bit wr0;
    int wr_data;
    int exp_beats;
    int exp_tuser;
    bit exp_err;
  } vec_t;

  vec_t tbl [10];
  vec_t post_rst;

  always #5 clk = ~clk;

  mmm_input_streamer #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .start_k(start_k), .start_new_b(start_new_b),
    .busy(busy), .done(done), .err(err), .OUT_TDATA(OUT_TDATA), .OUT_TVALID(OUT_TVALID),
    .OUT_TUSER(OUT_TUSER), .OUT_TREADY(OUT_TREADY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic host_write(input bit sel, input int addr, input int data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr[AW-1:0]; wr_data = data[INW-1:0];
    if (!sel) a_mdl[addr] = data[INW-1:0];
    else      b_mdl[addr] = data[INW-1:0];
  endtask

  // modes: 0 ready high, 1 ready 1,0,0,1, 2 random ready, 3 20-cycle stall at A->B,
  // 4 ready high with a busy start and a busy write injected mid-A
  task automatic run_set(input vec_t v);
    int nbeats = 0, ndone = 0, nerr = 0, nbusy = 0, stall = 0;
    int first_v = -1, first_b = -1, last_c = -1, done_c = -1;
    int mk, limit, exp_v;
    bit held = 1'b0;
    bit r;
    logic [INW-1:0] hd = '0;
    logic [KB:0]    hu = '0;
    mk = M * v.k;
    limit = v.exp_err ? 8 : 1500;
    @(negedge clk);
    start = 1'b1; start_k = v.k[KB-1:0]; start_new_b = v.nb;
    if (v.wr0) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = v.wr_data[INW-1:0];
      a_mdl[0] = v.wr_data[INW-1:0];
    end
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      if (c == 0) chk("busy_after_start", 32'(busy), 32'(!v.exp_err));
      if (held) begin
        chk("stall_valid", 32'(OUT_TVALID), 32'd1);
        chk("stall_data", 32'(OUT_TDATA), 32'(hd));
        chk("stall_user", 32'(OUT_TUSER), 32'(hu));
      end
      if (err) nerr++;
      if (busy && v.exp_err) nbusy++;
      if (done) begin ndone++; done_c = c; end
      if (done_c >= 0) chk("valid_low_after_last", 32'(OUT_TVALID), 32'd0);
      if (OUT_TVALID && first_v < 0) first_v = c;
      if (v.mode == 4 && c == 10) begin
        start = 1'b1; start_k = 4'd2; start_new_b = 1'b1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd30; wr_data = 12'hABC;
      end
      case (v.mode)
        1: r = (c % 4 == 0) || (c % 4 == 3);
        2: r = 1'($urandom_range(0, 1));
        3: begin
          if (OUT_TVALID && nbeats == mk - 1 && stall < 20) begin r = 1'b0; stall++; end
          else r = 1'b1;
        end
        default: r = 1'b1;
      endcase
      OUT_TREADY = r;
      if (OUT_TVALID && r) begin
        if (nbeats < mk)                exp_v = int'(a_mdl[nbeats]);
        else if (nbeats < mk + N * v.k) exp_v = int'(b_mdl[nbeats - mk]);
        else                            exp_v = -1;
        chk("beat_data", 32'(OUT_TDATA), 32'(exp_v));
        chk("beat_user", 32'(OUT_TUSER), 32'(v.exp_tuser));
        if (first_b < 0) first_b = c;
        last_c = c;
        nbeats++;
        held = 1'b0;
      end else if (OUT_TVALID) begin
        held = 1'b1; hd = OUT_TDATA; hu = OUT_TUSER;
      end else begin
        held = 1'b0;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    chk("beat_count", 32'(nbeats), 32'(v.exp_beats));
    chk("done_count", 32'(ndone), v.exp_err ? 32'd0 : 32'd1);
    chk("err_count", 32'(nerr), v.exp_err ? 32'd1 : 32'd0);
    if (v.exp_err) begin
      chk("busy_on_err", 32'(nbusy), 32'd0);
    end else begin
      chk("first_valid_latency", 32'(first_v >= 0 && first_v <= 2), 32'd1);
      chk("done_after_last_beat", 32'(done_c), 32'(last_c + 1));
    end
    if (v.mode == 0 && !v.exp_err) chk("back_to_back", 32'(last_c - first_b), 32'(nbeats - 1));
    if (v.mode == 3) chk("boundary_stall_len", 32'(stall), 32'd20);
  endtask

  initial begin
    int bc;
    bit found;
    int nd;
    tbl[0] = '{8, 1'b1, 0, 1'b0, 0, 128, 'h11, 1'b0};
    tbl[1] = '{3, 1'b0, 1, 1'b0, 0, 21, 'h06, 1'b0};
    tbl[2] = '{0, 1'b1, 0, 1'b0, 0, 0, 0, 1'b1};
    tbl[3] = '{9, 1'b1, 0, 1'b0, 0, 0, 0, 1'b1};
    tbl[4] = '{8, 1'b0, 4, 1'b0, 0, 56, 'h10, 1'b0};
    tbl[5] = '{8, 1'b1, 0, 1'b0, 0, 128, 'h11, 1'b0};
    tbl[6] = '{8, 1'b1, 3, 1'b0, 0, 128, 'h11, 1'b0};
    tbl[7] = '{1, 1'b1, 0, 1'b1, 'h7FF, 16, 'h03, 1'b0};
    tbl[8] = '{5, 1'b1, 2, 1'b0, 0, 80, 'h0B, 1'b0};
    tbl[9] = '{7, 1'b0, 1, 1'b0, 0, 49, 'h0E, 1'b0};
    post_rst = '{8, 1'b0, 0, 1'b0, 0, 56, 'h10, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(OUT_TVALID), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tdata", 32'(OUT_TDATA), 32'd0);
    chk("rst_tuser", 32'(OUT_TUSER), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 56; i++) host_write(1'b0, i, i + 1);
    for (int j = 0; j < 72; j++) host_write(1'b1, j, 100 + j);
    @(negedge clk);
    wr_en = 1'b0;

    for (int t = 0; t < 10; t++) run_set(tbl[t]);

    // Abort a K=8 set with reset while A beat 10 is on the bus.
    @(negedge clk);
    start = 1'b1; start_k = 4'd8; start_new_b = 1'b1; OUT_TREADY = 1'b1;
    bc = 0; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (OUT_TVALID) begin
        if (bc == 10) found = 1'b1;
        else bc++;
      end
    end
    chk("abort_reached_beat10", 32'(found), 32'd1);
    chk("abort_beat10_data", 32'(OUT_TDATA), 32'(a_mdl[10]));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(OUT_TVALID), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_tuser", 32'(OUT_TUSER), 32'd0);
    reset = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || OUT_TVALID) nd++;
    end
    chk("abort_quiet", 32'(nd), 32'd0);
    run_set(post_rst);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
